// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// The master modport is the controller side; the slave modport is the datapath side.
interface mc_ctrl_fsm_if #(
    parameter int unsigned RETIRE_W = 32
);
    logic [6:0]          op;
    logic                mem_ready;
    logic                stall;
    logic                mem_req;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ResultSrc;
    logic                AdrSrc;
    logic                IRWrite;
    logic                PCUpdate;
    logic                RegWrite;
    logic                MemWrite;
    logic [1:0]          ALUOp;
    logic                Branch;
    logic                instr_done;
    logic [RETIRE_W-1:0] retired;
    logic                bus_err;
    logic                trap;
    logic [4:0]          state_q;

    modport master (
        input  op, mem_ready, stall,
        output mem_req, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate,
               RegWrite, MemWrite, ALUOp, Branch, instr_done, retired, bus_err,
               trap, state_q
    );

    modport slave (
        output op, mem_ready, stall,
        input  mem_req, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, PCUpdate,
               RegWrite, MemWrite, ALUOp, Branch, instr_done, retired, bus_err,
               trap, state_q
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core with memory handshake, wait timeout and retire count.
// Define MC_CTRL_TRAP_EN to send illegal opcodes and memory timeouts to a halting TRAP state.
module mc_ctrl_fsm #(
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter int unsigned WAIT_TIMEOUT  = 0,
    parameter int unsigned RETIRE_W      = 32
) (
    input logic           clock,
    input logic           reset,
    mc_ctrl_fsm_if.master ctl
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,  S_DECODE   = 5'd1,  S_MEMADR   = 5'd2,  S_MEMREAD  = 5'd3,
        S_MEMWB    = 5'd4,  S_MEMWRITE = 5'd5,  S_EXECUTER = 5'd6,  S_ALUWB    = 5'd7,
        S_EXECUTEI = 5'd8,  S_JAL      = 5'd9,  S_BEQ      = 5'd10, S_LUI      = 5'd11,
        S_JALR     = 5'd12, S_JALRWB   = 5'd13, S_AUIPC    = 5'd14, S_TRAP     = 5'd15
    } state_t;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [1:0] alu_op;
        logic       adr;
        logic       pcu;
        logic       rw;
        logic       br;
    } sel_t;

`ifdef MC_CTRL_TRAP_EN
    localparam state_t FAULT_STATE = S_TRAP;
`else
    localparam state_t FAULT_STATE = S_FETCH;
`endif

    localparam logic [7:0] TIMEOUT_C = 8'(WAIT_TIMEOUT);

    // JALR loads the PC from rs1+imm itself; JALRWB then writes the link value OldPC+4.
    function automatic sel_t decode_sel(input state_t s);
        sel_t d;
        d = '0;
        case (s)
            S_FETCH:    begin d.src_b = 2'd2; d.res = 2'd2; end
            S_DECODE:   begin d.src_a = 2'd1; d.src_b = 2'd1; end
            S_MEMADR:   begin d.src_a = 2'd2; d.src_b = 2'd1; end
            S_MEMREAD:  d.adr = 1'b1;
            S_MEMWRITE: d.adr = 1'b1;
            S_MEMWB:    begin d.res = 2'd1; d.rw = 1'b1; end
            S_EXECUTER: begin d.src_a = 2'd2; d.alu_op = 2'd2; end
            S_EXECUTEI: begin d.src_a = 2'd2; d.src_b = 2'd1; d.alu_op = 2'd2; end
            S_ALUWB:    d.rw = 1'b1;
            S_BEQ:      begin d.src_a = 2'd2; d.alu_op = 2'd1; d.br = 1'b1; end
            S_JAL:      begin d.src_a = 2'd1; d.src_b = 2'd2; d.pcu = 1'b1; end
            S_LUI:      begin d.src_a = 2'd3; d.src_b = 2'd1; end
            S_JALR:     begin d.src_a = 2'd2; d.src_b = 2'd1; d.res = 2'd2; d.pcu = 1'b1; end
            S_JALRWB:   begin d.src_a = 2'd1; d.src_b = 2'd2; d.res = 2'd2; d.rw = 1'b1; end
            S_AUIPC:    begin d.src_a = 2'd1; d.src_b = 2'd1; end
            default:    d = '0;
        endcase
        return d;
    endfunction

    state_t              state_r;
    state_t              nxt_state_s;
    sel_t                sel_r;
    logic [7:0]          wait_cnt_r;
    logic [RETIRE_W-1:0] retired_r;
    logic                ready_s;
    logic                wait_st_s;
    logic                timeout_s;
    logic                req_s;
    logic                ack_s;
    logic                done_s;

    // Memory handshake qualifiers: request, acknowledge and wait timeout.
    always_comb begin
        ready_s   = MEM_HANDSHAKE ? ctl.mem_ready : 1'b1;
        wait_st_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
        timeout_s = (TIMEOUT_C != 8'd0) && wait_st_s && (wait_cnt_r == TIMEOUT_C);
        req_s     = wait_st_s && !timeout_s && !reset
                    && !((state_r == S_FETCH) && ctl.stall);
        ack_s     = req_s && ready_s;
    end

    // Retire detection.
    always_comb begin
        done_s = 1'b0;
        if (reset) begin
            done_s = 1'b0;
        end else begin
            done_s = (state_r == S_ALUWB) || (state_r == S_MEMWB) || (state_r == S_JALRWB)
                     || (state_r == S_BEQ) || ((state_r == S_MEMWRITE) && ack_s)
                     || ((state_r == S_DECODE) && (ctl.op == 7'd15));
        end
    end

    // Next-state selection.
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (timeout_s)  nxt_state_s = FAULT_STATE;
                else if (ack_s) nxt_state_s = S_DECODE;
                else            nxt_state_s = S_FETCH;
            end
            S_DECODE: begin
                case (ctl.op)
                    7'd3, 7'd35: nxt_state_s = S_MEMADR;
                    7'd19:       nxt_state_s = S_EXECUTEI;
                    7'd23:       nxt_state_s = S_AUIPC;
                    7'd51:       nxt_state_s = S_EXECUTER;
                    7'd55:       nxt_state_s = S_LUI;
                    7'd99:       nxt_state_s = S_BEQ;
                    7'd103:      nxt_state_s = S_JALR;
                    7'd111:      nxt_state_s = S_JAL;
                    7'd15:       nxt_state_s = S_FETCH;
                    default:     nxt_state_s = FAULT_STATE;
                endcase
            end
            S_MEMADR:   nxt_state_s = ctl.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (timeout_s)  nxt_state_s = FAULT_STATE;
                else if (ack_s) nxt_state_s = S_MEMWB;
                else            nxt_state_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (timeout_s)  nxt_state_s = FAULT_STATE;
                else if (ack_s) nxt_state_s = S_FETCH;
                else            nxt_state_s = S_MEMWRITE;
            end
            S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI, S_AUIPC: nxt_state_s = S_ALUWB;
            S_JALR:     nxt_state_s = S_JALRWB;
            S_ALUWB, S_MEMWB, S_JALRWB, S_BEQ:             nxt_state_s = S_FETCH;
            S_TRAP:     nxt_state_s = FAULT_STATE;
            default:    nxt_state_s = S_FETCH;
        endcase
    end

    // State, registered selects, wait counter and retire counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= S_FETCH;
            sel_r      <= decode_sel(S_FETCH);
            wait_cnt_r <= 8'd0;
            retired_r  <= '0;
        end else begin
            state_r <= nxt_state_s;
            sel_r   <= decode_sel(nxt_state_s);
            if (done_s) retired_r <= retired_r + {{(RETIRE_W-1){1'b0}}, 1'b1};
            if ((nxt_state_s != state_r) || ack_s || timeout_s) wait_cnt_r <= 8'd0;
            else if (req_s)                                     wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    assign ctl.mem_req    = req_s;
    assign ctl.ALUSrcA    = sel_r.src_a;
    assign ctl.ALUSrcB    = sel_r.src_b;
    assign ctl.ResultSrc  = sel_r.res;
    assign ctl.AdrSrc     = sel_r.adr;
    assign ctl.ALUOp      = sel_r.alu_op;
    assign ctl.Branch     = sel_r.br;
    assign ctl.IRWrite    = (state_r == S_FETCH) && ack_s;
    assign ctl.PCUpdate   = !reset && (sel_r.pcu || ((state_r == S_FETCH) && ack_s));
    assign ctl.RegWrite   = !reset && sel_r.rw;
    assign ctl.MemWrite   = (state_r == S_MEMWRITE) && req_s;
    assign ctl.instr_done = done_s;
    assign ctl.retired    = retired_r;
    assign ctl.bus_err    = timeout_s && !reset;
    assign ctl.state_q    = state_r;
`ifdef MC_CTRL_TRAP_EN
    assign ctl.trap       = (state_r == S_TRAP) && !reset;
`else
    assign ctl.trap       = 1'b0;
`endif

endmodule
